// File: rtl/seq_fsm_pkg.sv
// Shared types and helpers for the cyclic sequencer: state-width function,
// parameter legality check and the wide state-index type.
package seq_fsm_pkg;

  localparam int MAX_SW = 8;

  typedef logic [MAX_SW-1:0] state_idx_t;

  typedef enum logic [1:0] {
    TR_HOLD,
    TR_STEP,
    TR_RESTART,
    TR_WRAP
  } tr_kind_t;

  function automatic int state_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  function automatic bit params_ok(input int n, input int br, input int lo,
                                   input int hi, input int cw, input int cnw);
    return (n >= 4) && (n <= 256) && (br >= 1) && (br <= n - 2) &&
           (lo >= 0) && (lo <= hi) && (hi < n) && (cw >= 1) && (cnw >= 1);
  endfunction

endpackage

// File: rtl/seq_fsm_gen_sat_counter.sv
// Saturating up-counter with synchronous clear; used for the pass count.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] cnt
);

  logic [W-1:0] cnt_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg <= '0;
    end else if (clr) begin
      cnt_reg <= '0;
    end else if (inc && (cnt_reg != {W{1'b1}})) begin
      cnt_reg <= cnt_reg + W'(1);
    end
  end

  assign cnt = cnt_reg;

endmodule

// File: rtl/seq_fsm_gen.sv
// Cyclic sequencer with one branch point, a cond-gated output window and a
// saturating pass counter. Define SEQ_FSM_GEN_REG_OUT_EN to register outp.
module seq_fsm_gen
  import seq_fsm_pkg::*;
#(
  parameter int N_STATES  = 8,
  parameter int COND_W    = 3,
  parameter int BRANCH_ST = 3,
  parameter int OUT_LO    = 2,
  parameter int OUT_HI    = 3,
  parameter int CNT_W     = 8,
  localparam int SW       = state_w(N_STATES)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              clr,
  input  logic [COND_W-1:0] cond,
  input  logic [COND_W-1:0] branch_mask,
  input  logic [COND_W-1:0] out_mask,
  output logic [SW-1:0]     state,
  output logic              outp,
  output logic              done,
  output logic [CNT_W-1:0]  pass_cnt
);

  if (!params_ok(N_STATES, BRANCH_ST, OUT_LO, OUT_HI, COND_W, CNT_W)) begin : g_param_err
    $error("seq_fsm_gen: illegal parameter combination");
  end

  logic [SW-1:0] state_reg;
  logic          done_reg;
  state_idx_t    st_wide;
  tr_kind_t      tr;
  logic          br_hit;
  logic          out_hit;
  logic          in_window;
  logic          outp_comb;

  assign st_wide = state_idx_t'(state_reg);
  assign br_hit  = |(cond & branch_mask);
  assign out_hit = |(cond & out_mask);

  // Illegal encodings restart without counting, same as a short pass.
  always_comb begin
    tr = TR_STEP;
    if (!en) begin
      tr = TR_HOLD;
    end else if (int'(st_wide) >= N_STATES) begin
      tr = TR_RESTART;
    end else if (int'(st_wide) == BRANCH_ST) begin
      tr = br_hit ? TR_STEP : TR_RESTART;
    end else if (int'(st_wide) == N_STATES - 1) begin
      tr = TR_WRAP;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= '0;
      done_reg  <= 1'b0;
    end else if (clr) begin
      state_reg <= '0;
      done_reg  <= 1'b0;
    end else begin
      done_reg <= (tr == TR_WRAP);
      case (tr)
        TR_HOLD: state_reg <= state_reg;
        TR_STEP: state_reg <= state_reg + SW'(1);
        default: state_reg <= '0;
      endcase
    end
  end

  sat_counter #(
    .W(CNT_W)
  ) u_pass_cnt (
    .clk  (clk),
    .rst_n(rst_n),
    .inc  (tr == TR_WRAP),
    .clr  (clr),
    .cnt  (pass_cnt)
  );

  assign in_window = (int'(st_wide) >= OUT_LO) && (int'(st_wide) <= OUT_HI);
  assign outp_comb = in_window && out_hit;

`ifdef SEQ_FSM_GEN_REG_OUT_EN
  logic outp_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      outp_reg <= 1'b0;
    end else if (clr) begin
      outp_reg <= 1'b0;
    end else begin
      outp_reg <= outp_comb;
    end
  end

  assign outp = outp_reg;
`else
  assign outp = outp_comb;
`endif

  assign state = state_reg;
  assign done  = done_reg;

endmodule

// File: tb/tb_seq_fsm_gen.sv
// Directed bench for seq_fsm_gen: a default 8-state instance and a
// 6-state instance with a 2-bit pass counter share one set of inputs.
module tb_seq_fsm_gen;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic       clr;
  logic [2:0] cond;
  logic [2:0] branch_mask;
  logic [2:0] out_mask;

  logic [2:0] a_state;
  logic       a_outp;
  logic       a_done;
  logic [7:0] a_cnt;

  logic [2:0] b_state;
  logic       b_outp;
  logic       b_done;
  logic [1:0] b_cnt;

  int n_tests = 0;
  int n_fail  = 0;
  bit prev_v  = 1'b0;

  seq_fsm_gen dut_a (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .clr        (clr),
    .cond       (cond),
    .branch_mask(branch_mask),
    .out_mask   (out_mask),
    .state      (a_state),
    .outp       (a_outp),
    .done       (a_done),
    .pass_cnt   (a_cnt)
  );

  seq_fsm_gen #(
    .N_STATES (6),
    .COND_W   (3),
    .BRANCH_ST(3),
    .OUT_LO   (2),
    .OUT_HI   (3),
    .CNT_W    (2)
  ) dut_b (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .clr        (clr),
    .cond       (cond),
    .branch_mask(branch_mask),
    .out_mask   (out_mask),
    .state      (b_state),
    .outp       (b_outp),
    .done       (b_done),
    .pass_cnt   (b_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end else begin
      $display("[TB] %s: %0d ok", tag, obs);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Window is states 2..3 on dut_a; the registered build lags by one cycle.
  task automatic check_out(input string tag, input int st);
    bit cur_v;
    cur_v = (st >= 2) && (st <= 3) && (|(cond & out_mask));
`ifdef SEQ_FSM_GEN_REG_OUT_EN
    check_val(tag, {31'd0, a_outp}, {31'd0, prev_v});
`else
    check_val(tag, {31'd0, a_outp}, {31'd0, cur_v});
`endif
    prev_v = cur_v;
  endtask

  initial begin
    int done_seen;
    int exp_cnt;

    rst_n       = 1'b0;
    en          = 1'b1;
    clr         = 1'b0;
    cond        = 3'b010;
    branch_mask = 3'b010;
    out_mask    = 3'b000;
    #12;
    check_val("rst_a_state", a_state, 0);
    check_val("rst_a_outp", a_outp, 0);
    check_val("rst_a_done", a_done, 0);
    check_val("rst_a_cnt", a_cnt, 0);
    check_val("rst_b_state", b_state, 0);
    rst_n = 1'b1;

    // 1: three full passes with the branch taken
    for (int c = 1; c <= 24; c++) begin
      tick();
      check_val("t1_state", a_state, c % 8);
      check_val("t1_done", a_done, (c % 8 == 0) ? 1 : 0);
      check_val("t1_cnt", a_cnt, c / 8);
    end

    // 2: branch not taken gives short passes that never count
    cond = 3'b001;
    clr  = 1'b1;
    tick();
    clr = 1'b0;
    check_val("t2_clr_state", a_state, 0);
    check_val("t2_clr_cnt", a_cnt, 0);
    for (int c = 1; c <= 12; c++) begin
      tick();
      check_val("t2_state", a_state, c % 4);
      check_val("t2_done", a_done, 0);
      check_val("t2_cnt", a_cnt, 0);
    end

    // 3: output window qualified by cond & out_mask
    out_mask = 3'b101;
    cond     = 3'b000;
    prev_v   = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      tick();
      cond = (c <= 4) ? 3'b100 : 3'b000;
      #1;
      check_val("t3_state", a_state, c % 4);
      check_out("t3_outp", c % 4);
    end

    // 4: hold in state 2 with en low, window stays active
    cond = 3'b100;
    for (int c = 1; c <= 2; c++) begin
      tick();
      check_out("t4_outp_run", c);
    end
    check_val("t4_state_run", a_state, 2);
    en = 1'b0;
    for (int c = 1; c <= 5; c++) begin
      tick();
      check_val("t4_state_hold", a_state, 2);
      check_val("t4_done_hold", a_done, 0);
      check_out("t4_outp_hold", 2);
    end
    en = 1'b1;

    // 5: 6-state instance, 2-bit counter saturates, clr wins on wrap
    cond        = 3'b010;
    branch_mask = 3'b010;
    out_mask    = 3'b000;
    clr         = 1'b1;
    tick();
    clr = 1'b0;
    check_val("t5_clr_state", b_state, 0);
    check_val("t5_clr_cnt", b_cnt, 0);
    done_seen = 0;
    for (int c = 1; c <= 30; c++) begin
      tick();
      exp_cnt = (c / 6 > 3) ? 3 : c / 6;
      check_val("t5_state", b_state, c % 6);
      check_val("t5_done", b_done, (c % 6 == 0) ? 1 : 0);
      check_val("t5_cnt", b_cnt, exp_cnt);
      if (b_done) done_seen++;
    end
    check_val("t5_done_pulses", done_seen, 5);
    for (int c = 31; c <= 35; c++) tick();
    check_val("t5_state_final", b_state, 5);
    check_val("t5_cnt_sat", b_cnt, 3);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    check_val("t5_wrapclr_state", b_state, 0);
    check_val("t5_wrapclr_cnt", b_cnt, 0);
    check_val("t5_wrapclr_done", b_done, 0);
    tick();
    check_val("t5_after_done", b_done, 0);
    check_val("t5_after_state", b_state, 1);

    // 6: asynchronous reset mid-pass in state 4
    out_mask = 3'b010;
    for (int c = 1; c <= 9; c++) tick();
    check_val("t6_pre_state", b_state, 4);
    check_val("t6_pre_cnt", b_cnt, 1);
    rst_n = 1'b0;
    #1;
    check_val("t6_rst_state", b_state, 0);
    check_val("t6_rst_outp", b_outp, 0);
    check_val("t6_rst_done", b_done, 0);
    check_val("t6_rst_cnt", b_cnt, 0);
    check_val("t6_rst_a_outp", a_outp, 0);
    tick();
    check_val("t6_rst_hold", b_state, 0);
    rst_n = 1'b1;
    for (int c = 1; c <= 14; c++) begin
      tick();
      check_val("t6_restart_state", b_state, c % 6);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
